csd_stream_conv: RTL and testbench

Parametrised binary-to-CSD (canonical signed digit) conversion engine, successor to the single-width 8-bit converter. It holds a WIDTH×DEPTH operand store that the host loads through a write port. On `start` it converts a programmable run of words, one CSD digit per clock, into positive/negative digit masks. Each result is offered on a valid/ready output port, with a signed/unsigned mode selection and a non-zero-digit count per word, for use by downstream shift-add multiplier generators.

---
 rtl/csd_pkg.sv | 31 +++
 rtl/csd_word_mem.sv | 34 +++
 rtl/csd_stream_conv.sv | 176 +++++++++++++++++
 tb/tb_csd_stream_conv.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csd_pkg.sv
// Shared types and the one-step Reitwiesner digit/carry rule for the CSD stream converter.
package csd_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        CONV  = 3'd2,
        EMIT  = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [1:0] ZERO = 2'b00;
    localparam logic [1:0] POS  = 2'b01;
    localparam logic [1:0] NEG  = 2'b10;

    // Returns {carry_out, digit}; carry is the majority of the three inputs.
    function automatic logic [2:0] csd_step(input logic xi, input logic xi1, input logic ci);
        logic       cn;
        logic [1:0] d;
        cn = (xi & xi1) | (xi & ci) | (xi1 & ci);
        if (!cn && (xi || ci)) begin
            d = POS;
        end else if (cn && !(xi && ci)) begin
            d = NEG;
        end else begin
            d = ZERO;
        end
        return {cn, d};
    endfunction

endpackage

// File: rtl/csd_word_mem.sv
// Operand store: register array with a synchronous write port and a registered read port.
module csd_word_mem #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // A same-cycle write to raddr is not visible here; the old word is returned.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/csd_stream_conv.sv
// Binary-to-CSD stream converter: runs over a window of the operand store, one digit per clock,
// and offers each word's +1/-1 digit masks and non-zero digit count on a valid/ready port.
module csd_stream_conv #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned NW   = $clog2(WIDTH + 2)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             weCsd,
    input  logic [AW-1:0]    address,
    input  logic [WIDTH-1:0] dataIn,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [AW-1:0]    base_addr,
    input  logic [AW:0]      count,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [AW-1:0]    out_addr,
    output logic [WIDTH:0]   out_pos,
    output logic [WIDTH:0]   out_neg,
    output logic [NW-1:0]    out_nzd,
    output logic             busy,
    output logic             done
);
    import csd_pkg::*;

    localparam int unsigned BW = $clog2(WIDTH + 1);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned XW = WIDTH + 2;

    state_t           state_q, state_d;
    logic [AW-1:0]    rd_addr_q, rd_addr_d;
    logic [CW-1:0]    remain_q, remain_d;
    logic             sgn_q, sgn_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic             carry_q, carry_d;
    logic [WIDTH:0]   pos_sr_q, pos_sr_d;
    logic [WIDTH:0]   neg_sr_q, neg_sr_d;
    logic [NW-1:0]    nzd_q, nzd_d;

    logic             out_valid_d, busy_d, done_d;
    logic [AW-1:0]    out_addr_d;
    logic [WIDTH:0]   out_pos_d, out_neg_d;
    logic [NW-1:0]    out_nzd_d;

    logic [WIDTH-1:0] word;
    logic [XW-1:0]    xe;
    logic [XW-1:0]    xs;
    logic [2:0]       step;

    csd_word_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .reset (reset),
        .we    (weCsd),
        .waddr (address),
        .wdata (dataIn),
        .re    (state_q == FETCH),
        .raddr (rd_addr_q),
        .rdata (word)
    );

    // Extended operand; the read register holds the word for the whole CONV phase.
    always_comb begin
        xe   = sgn_q ? {{2{word[WIDTH-1]}}, word} : {2'b00, word};
        xs   = xe >> bit_q;
        step = csd_step(xs[0], xs[1], carry_q);
    end

    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        remain_d  = remain_q;
        sgn_d     = sgn_q;
        bit_d     = bit_q;
        carry_d   = carry_q;
        pos_sr_d  = pos_sr_q;
        neg_sr_d  = neg_sr_q;
        nzd_d     = nzd_q;
        out_addr_d = out_addr;
        out_pos_d  = out_pos;
        out_neg_d  = out_neg;
        out_nzd_d  = out_nzd;

        case (state_q)
            IDLE: begin
                if (start) begin
                    sgn_d     = signed_mode;
                    rd_addr_d = base_addr;
                    remain_d  = count;
                    state_d   = (count == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                bit_d   = '0;
                carry_d = 1'b0;
                nzd_d   = '0;
                state_d = CONV;
            end
            CONV: begin
                carry_d  = step[2];
                pos_sr_d = {step[1:0] == POS, pos_sr_q[WIDTH:1]};
                neg_sr_d = {step[1:0] == NEG, neg_sr_q[WIDTH:1]};
                nzd_d    = nzd_q + NW'(step[1:0] != ZERO);
                bit_d    = bit_q + BW'(1);
                if (bit_q == BW'(WIDTH)) begin
                    state_d    = EMIT;
                    out_addr_d = rd_addr_q;
                    out_pos_d  = pos_sr_d;
                    out_neg_d  = neg_sr_d;
                    out_nzd_d  = nzd_d;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    rd_addr_d = rd_addr_q + AW'(1);
                    remain_d  = remain_q - CW'(1);
                    state_d   = (remain_q == CW'(1)) ? DONE : FETCH;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        out_valid_d = (state_d == EMIT);
        busy_d      = (state_d == FETCH) || (state_d == CONV) || (state_d == EMIT);
        done_d      = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            rd_addr_q <= '0;
            remain_q  <= '0;
            sgn_q     <= 1'b0;
            bit_q     <= '0;
            carry_q   <= 1'b0;
            pos_sr_q  <= '0;
            neg_sr_q  <= '0;
            nzd_q     <= '0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_pos   <= '0;
            out_neg   <= '0;
            out_nzd   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_addr_q <= rd_addr_d;
            remain_q  <= remain_d;
            sgn_q     <= sgn_d;
            bit_q     <= bit_d;
            carry_q   <= carry_d;
            pos_sr_q  <= pos_sr_d;
            neg_sr_q  <= neg_sr_d;
            nzd_q     <= nzd_d;
            out_valid <= out_valid_d;
            out_addr  <= out_addr_d;
            out_pos   <= out_pos_d;
            out_neg   <= out_neg_d;
            out_nzd   <= out_nzd_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

endmodule

// File: tb/tb_csd_stream_conv.sv
// Self-checking bench for csd_stream_conv: vector table, hand-written corner sequences and a
// randomized run, all checked through a scoreboard queue on every output transfer.
module tb_csd_stream_conv;
    import csd_pkg::*;

    localparam int unsigned W     = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;
    localparam int unsigned CW    = AW + 1;
    localparam int unsigned NW    = $clog2(W + 2);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          weCsd;
    logic [AW-1:0] address;
    logic [W-1:0]  dataIn;
    logic          start;
    logic          signed_mode;
    logic [AW-1:0] base_addr;
    logic [AW:0]   count;
    logic          out_ready;
    logic          out_valid;
    logic [AW-1:0] out_addr;
    logic [W:0]    out_pos;
    logic [W:0]    out_neg;
    logic [NW-1:0] out_nzd;
    logic          busy;
    logic          done;

    csd_stream_conv #(.WIDTH(W), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (rst_n),
        .weCsd       (weCsd),
        .address     (address),
        .dataIn      (dataIn),
        .start       (start),
        .signed_mode (signed_mode),
        .base_addr   (base_addr),
        .count       (count),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_addr    (out_addr),
        .out_pos     (out_pos),
        .out_neg     (out_neg),
        .out_nzd     (out_nzd),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [W:0]    pos;
        logic [W:0]    neg;
        logic [NW-1:0] nzd;
        longint        val;
    } exp_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [W-1:0]  data;
        logic          sgn;
        logic [W:0]    pos;
        logic [W:0]    neg;
        logic [NW-1:0] nzd;
    } vec_t;

    exp_t         sbq[$];
    exp_t         mon_e;
    int           xfer_log[$];
    logic [W-1:0] shadow [DEPTH];
    vec_t         tbl [10];

    int total = 0, bad = 0;
    int cyc = 0, start_edge = 0;
    int done_cnt = 0, done_cyc = -1, xfer_cnt = 0, last_xfer = -1, valid_cycles = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic longint opval(input logic [W-1:0] d, input logic s);
        return s ? longint'($signed(d)) : longint'(d);
    endfunction

    function automatic longint csd_value(input logic [W:0] p, input logic [W:0] n);
        longint v = 0;
        for (int i = 0; i <= W; i++) begin
            if (p[i]) v = v + (longint'(1) << i);
            if (n[i]) v = v - (longint'(1) << i);
        end
        return v;
    endfunction

    function automatic exp_t model(input logic [AW-1:0] a, input logic [W-1:0] d, input logic s);
        exp_t         e;
        logic [W+1:0] x;
        logic         c;
        logic [2:0]   r;
        x = s ? {{2{d[W-1]}}, d} : {2'b00, d};
        c = 1'b0;
        e.addr = a; e.pos = '0; e.neg = '0; e.nzd = '0;
        for (int i = 0; i <= W; i++) begin
            r = csd_step(x[i], x[i+1], c);
            c = r[2];
            if (r[1:0] == POS) e.pos[i] = 1'b1;
            if (r[1:0] == NEG) e.neg[i] = 1'b1;
            if (r[1:0] != ZERO) e.nzd = e.nzd + NW'(1);
        end
        e.val = opval(d, s);
        return e;
    endfunction

    // Transfer monitor: pops the scoreboard and checks the word plus CSD invariants.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) valid_cycles++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (out_valid && out_ready) begin
                xfer_cnt++;
                last_xfer = cyc + 1;
                xfer_log.push_back(cyc + 1);
                if (sbq.size() == 0) begin
                    chk("unexpected_xfer", longint'(out_addr), -1);
                end else begin
                    mon_e = sbq.pop_front();
                    chk("addr", out_addr, mon_e.addr);
                    chk("pos", out_pos, mon_e.pos);
                    chk("neg", out_neg, mon_e.neg);
                    chk("nzd", out_nzd, mon_e.nzd);
                    chk("value", csd_value(out_pos, out_neg), mon_e.val);
                    chk("pos_and_neg", out_pos & out_neg, 0);
                    chk("adjacent", (out_pos | out_neg) & ((out_pos | out_neg) >> 1), 0);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d);
        weCsd = 1'b1; address = a; dataIn = d; shadow[a] = d;
        tick();
        weCsd = 1'b0;
    endtask

    task automatic push_model(input logic [AW-1:0] base, input int cnt, input logic s);
        logic [AW-1:0] a;
        for (int k = 0; k < cnt; k++) begin
            a = base + AW'(k);
            sbq.push_back(model(a, shadow[a], s));
        end
    endtask

    task automatic push_vec(input int i);
        exp_t e;
        e.addr = tbl[i].addr; e.pos = tbl[i].pos; e.neg = tbl[i].neg; e.nzd = tbl[i].nzd;
        e.val  = opval(tbl[i].data, tbl[i].sgn);
        sbq.push_back(e);
    endtask

    task automatic launch_raw(input logic [AW-1:0] base, input int cnt, input logic s);
        base_addr = base; count = CW'(cnt); signed_mode = s;
        start_edge = cyc + 1;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit drop_start);
        int n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        if (drop_start) start = 1'b0;
        chk("run_done", done, 1);
        tick();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_addr"}, out_addr, 0);
        chk({tag, "_out_pos"}, out_pos, 0);
        chk({tag, "_out_neg"}, out_neg, 0);
        chk({tag, "_out_nzd"}, out_nzd, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int dc0, xc0, vc0, n;
        logic [W-1:0] rv;

        tbl[0] = '{4'd0,  8'h01, 1'b0, 9'h001, 9'h000, 4'd1};
        tbl[1] = '{4'd1,  8'h03, 1'b0, 9'h004, 9'h001, 4'd2};
        tbl[2] = '{4'd2,  8'h37, 1'b0, 9'h040, 9'h009, 4'd3};
        tbl[3] = '{4'd5,  8'hFF, 1'b0, 9'h100, 9'h001, 4'd2};
        tbl[4] = '{4'd5,  8'hFF, 1'b1, 9'h000, 9'h001, 4'd1};
        tbl[5] = '{4'd6,  8'h80, 1'b1, 9'h000, 9'h080, 4'd1};
        tbl[6] = '{4'd6,  8'h80, 1'b0, 9'h080, 9'h000, 4'd1};
        tbl[7] = '{4'd7,  8'h55, 1'b0, 9'h055, 9'h000, 4'd4};
        tbl[8] = '{4'd7,  8'h7F, 1'b1, 9'h080, 9'h001, 4'd2};
        tbl[9] = '{4'd15, 8'h00, 1'b1, 9'h000, 9'h000, 4'd0};

        rst_n = 1'b0; weCsd = 1'b0; address = '0; dataIn = '0; start = 1'b0;
        signed_mode = 1'b0; base_addr = '0; count = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        // Single-word runs from the vector table.
        for (int i = 0; i < 10; i++) begin
            wr(tbl[i].addr, tbl[i].data);
            push_vec(i);
            launch_raw(tbl[i].addr, 1, tbl[i].sgn);
            wait_done(40, 0);
        end

        // Three-word run: latency, throughput and done timing.
        wr(0, 8'h01); wr(1, 8'h03); wr(2, 8'h37);
        push_vec(0); push_vec(1); push_vec(2);
        xfer_log.delete();
        dc0 = done_cnt;
        launch_raw(0, 3, 1'b0);
        wait_done(60, 0);
        chk("run3_xfers", xfer_log.size(), 3);
        if (xfer_log.size() == 3) begin
            chk("first_latency", xfer_log[0] - start_edge, W + 3);
            chk("period_1", xfer_log[1] - xfer_log[0], W + 3);
            chk("period_2", xfer_log[2] - xfer_log[1], W + 3);
        end
        chk("done_after_last", done_cyc, last_xfer);
        chk("done_once", done_cnt - dc0, 1);

        // Run wrapping past the top of the store.
        wr(14, W'($urandom)); wr(15, W'($urandom)); wr(0, W'($urandom)); wr(1, W'($urandom));
        push_model(14, 4, 1'b0);
        launch_raw(14, 4, 1'b0);
        wait_done(80, 0);
        chk("wrap_sb_empty", sbq.size(), 0);

        // Backpressure: result held while out_ready is low.
        wr(5, 8'hFF);
        push_vec(3);
        out_ready = 1'b0;
        launch_raw(5, 1, 1'b0);
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        chk("bp_valid", out_valid, 1);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_pos", out_pos, 9'h100);
            chk("bp_hold_neg", out_neg, 9'h001);
            chk("bp_hold_nzd", out_nzd, 2);
        end
        xc0 = xfer_cnt;
        out_ready = 1'b1;
        wait_done(20, 0);
        chk("bp_one_xfer", xfer_cnt - xc0, 1);
        chk("bp_sb_empty", sbq.size(), 0);

        // Zero-length run.
        vc0 = valid_cycles; dc0 = done_cnt;
        launch_raw(3, 0, 1'b0);
        wait_done(5, 0);
        chk("cnt0_done_timing", done_cyc, start_edge);
        chk("cnt0_done_once", done_cnt - dc0, 1);
        chk("cnt0_no_valid", valid_cycles - vc0, 0);

        // start held high through a whole run launches only one run.
        wr(3, W'($urandom)); wr(4, W'($urandom));
        push_model(3, 2, 1'b0);
        xc0 = xfer_cnt;
        base_addr = 4'd3; count = CW'(2); signed_mode = 1'b0;
        start = 1'b1;
        wait_done(60, 1);
        repeat (20) tick();
        chk("held_start_xfers", xfer_cnt - xc0, 2);
        chk("held_start_idle", busy, 0);
        chk("held_start_sb", sbq.size(), 0);

        // Write to a word not yet fetched during a run.
        wr(8, W'($urandom)); wr(9, W'($urandom)); wr(10, 8'h00);
        rv = W'($urandom) | 8'h81;
        sbq.push_back(model(8, shadow[8], 1'b1));
        sbq.push_back(model(9, shadow[9], 1'b1));
        sbq.push_back(model(10, rv, 1'b1));
        launch_raw(8, 3, 1'b1);
        tick(); tick();
        wr(10, rv);
        wait_done(80, 0);
        chk("late_write_sb", sbq.size(), 0);

        // Reset in the middle of CONV aborts the run.
        wr(2, 8'h37);
        dc0 = done_cnt;
        launch_raw(2, 1, 1'b0);
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        tick();
        rst_n = 1'b1;
        sbq.delete();
        repeat (3) tick();
        chk("midrst_no_done", done_cnt - dc0, 0);
        push_vec(2);
        launch_raw(2, 1, 1'b0);
        wait_done(40, 0);
        chk("midrst_rerun_sb", sbq.size(), 0);

        // Randomized full-depth runs in both modes.
        for (int m = 0; m < 2; m++) begin
            for (int b = 0; b < 63; b++) begin
                for (int a = 0; a < DEPTH; a++) wr(AW'(a), W'($urandom));
                rv = W'($urandom);
                push_model(rv[AW-1:0], DEPTH, m[0]);
                launch_raw(rv[AW-1:0], DEPTH, m[0]);
                wait_done(DEPTH * (W + 3) + 30, 0);
            end
        end
        chk("final_sb_empty", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
